amp_cfg_sequencer: RTL and testbench

Upstream feeder for amp_i2c_master. It holds the amplifier's power-up register table and hands the entries to the master one at a time over a valid/ready request and done/nack completion handshake. A rising edge on send_cfg starts one sequence. The block retries NACKed writes, times out stalled transfers, and reports busy/done/error status to the top level.

---
 rtl/amp_cfg_sequencer_if.sv | 30 +++
 rtl/amp_cfg_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_amp_cfg_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amp_cfg_sequencer_if.sv
// Write-request channel between amp_cfg_sequencer (master side) and amp_i2c_master (slave side).
interface amp_cfg_sequencer_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [6:0] wr_dev_addr;
    logic [7:0] wr_reg_addr;
    logic [7:0] wr_data;
    logic       wr_done;
    logic       wr_nack;

    modport master (
        output wr_valid,
        output wr_dev_addr,
        output wr_reg_addr,
        output wr_data,
        input  wr_ready,
        input  wr_done,
        input  wr_nack
    );

    modport slave (
        input  wr_valid,
        input  wr_dev_addr,
        input  wr_reg_addr,
        input  wr_data,
        output wr_ready,
        output wr_done,
        output wr_nack
    );
endinterface

// File: rtl/amp_cfg_sequencer.sv
// Amplifier power-up sequencer: walks the register table, retries NACKs, times out stalls.
// Optional inter-write settling gap enabled by defining AMP_CFG_GAP_EN.
module amp_cfg_sequencer #(
    parameter logic [6:0]  DEV_ADDR       = 7'h2C,
    parameter int unsigned NUM_WRITES     = 6,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned GAP_CYCLES     = 100
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       send_cfg,
    amp_cfg_sequencer_if.master        bus,
    output logic                       cfg_busy,
    output logic                       cfg_done,
    output logic                       cfg_error,
    output logic [3:0]                 cfg_index
);

    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RETRY_W = 3;

    if (NUM_WRITES < 1 || NUM_WRITES > 16) begin : g_bad_num_writes
        $error("amp_cfg_sequencer: NUM_WRITES must be 1..16");
    end
    if (MAX_RETRY > 7) begin : g_bad_max_retry
        $error("amp_cfg_sequencer: MAX_RETRY must be 0..7");
    end
    if (TIMEOUT_CYCLES < 2 || GAP_CYCLES < 1) begin : g_bad_cycles
        $error("amp_cfg_sequencer: TIMEOUT_CYCLES must be >= 2 and GAP_CYCLES >= 1");
    end

`ifdef AMP_CFG_GAP_EN
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, REQ, WAIT, NEXT, DONE, ERROR, GAP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, LOAD, REQ, WAIT, NEXT, DONE, ERROR
    } state_t;
`endif

    state_t               state_q, state_d;
    logic                 send_q, send_prev_q;
    logic                 wr_valid_q, wr_valid_d;
    logic [7:0]           reg_q, reg_d;
    logic [7:0]           data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic [3:0]           index_q, index_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
`ifdef AMP_CFG_GAP_EN
    logic [GAP_W-1:0]     gap_q, gap_d;
`endif

    logic start_edge_c;
    logic last_entry_c;

    // Power-up register table: {reg_addr, data}
    function automatic logic [15:0] rom_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    rom_entry = 16'h0001;
            4'd1:    rom_entry = 16'h0180;
            4'd2:    rom_entry = 16'h021F;
            4'd3:    rom_entry = 16'h031F;
            4'd4:    rom_entry = 16'h1005;
            4'd5:    rom_entry = 16'h2001;
            default: rom_entry = 16'hFF00;
        endcase
    endfunction

    // Edge detect lags one cycle behind the input register; both reset high so a held level never starts.
    assign start_edge_c = send_q & ~send_prev_q;
    assign last_entry_c = (index_q == 4'(NUM_WRITES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            send_q      <= 1'b1;
            send_prev_q <= 1'b1;
            wr_valid_q  <= 1'b0;
            reg_q       <= 8'd0;
            data_q      <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            index_q     <= 4'd0;
            retry_q     <= '0;
            timer_q     <= '0;
`ifdef AMP_CFG_GAP_EN
            gap_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            send_q      <= send_cfg;
            send_prev_q <= send_q;
            wr_valid_q  <= wr_valid_d;
            reg_q       <= reg_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            index_q     <= index_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
`ifdef AMP_CFG_GAP_EN
            gap_q       <= gap_d;
`endif
        end
    end

    // Next-state and next-output logic; status flags change on entry to DONE/ERROR so they line up with the state.
    always_comb begin
        state_d    = state_q;
        wr_valid_d = 1'b0;
        reg_d      = reg_q;
        data_d     = data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        index_d    = index_q;
        retry_d    = retry_q;
        timer_d    = timer_q;
`ifdef AMP_CFG_GAP_EN
        gap_d      = gap_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start_edge_c) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    index_d = 4'd0;
                    retry_d = '0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                {reg_d, data_d} = rom_entry(index_q);
                wr_valid_d      = 1'b1;
                state_d         = REQ;
            end
            REQ: begin
                wr_valid_d = 1'b1;
                if (wr_valid_q && bus.wr_ready) begin
                    wr_valid_d = 1'b0;
                    timer_d    = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                timer_d = timer_q + TIMER_W'(1);
                if (bus.wr_done) begin
                    if (!bus.wr_nack) begin
                        state_d = NEXT;
                    end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_d    = retry_q + RETRY_W'(1);
                        wr_valid_d = 1'b1;
                        state_d    = REQ;
                    end else begin
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                        state_d = ERROR;
                    end
                end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    state_d = ERROR;
                end
            end
            NEXT: begin
                retry_d = '0;
                if (last_entry_c) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    index_d = index_q + 4'd1;
`ifdef AMP_CFG_GAP_EN
                    gap_d   = '0;
                    state_d = GAP;
`else
                    state_d = LOAD;
`endif
                end
            end
`ifdef AMP_CFG_GAP_EN
            GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = LOAD;
                end
            end
`endif
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.wr_valid    = wr_valid_q;
    assign bus.wr_dev_addr = DEV_ADDR;
    assign bus.wr_reg_addr = reg_q;
    assign bus.wr_data     = data_q;
    assign cfg_busy        = busy_q;
    assign cfg_done        = done_q;
    assign cfg_error       = error_q;
    assign cfg_index       = index_q;

endmodule

// File: tb/tb_amp_cfg_sequencer.sv
// Scoreboard bench for amp_cfg_sequencer: stimulus queues expected requests, a monitor pops and compares.
module tb_amp_cfg_sequencer;

    localparam int unsigned TMO = 100;
    localparam int unsigned GAP = 10;

    logic       clk;
    logic       reset;
    logic       send_cfg;
    logic       cfg_busy;
    logic       cfg_done;
    logic       cfg_error;
    logic [3:0] cfg_index;

    amp_cfg_sequencer_if bus();

    amp_cfg_sequencer #(
        .DEV_ADDR       (7'h2C),
        .NUM_WRITES     (6),
        .MAX_RETRY      (3),
        .TIMEOUT_CYCLES (TMO),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .send_cfg  (send_cfg),
        .bus       (bus),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error),
        .cfg_index (cfg_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          errors;
    int          checks;
    logic [22:0] exp_q[$];
    int          req_cnt;
    int          watch_hits;
    logic [7:0]  watch_reg;
    logic [7:0]  nack_reg;
    int          nack_left;
    bit          respond_en;
    int          acc_cyc;
    int          done_cyc;
    bit          gap_pending;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] r, input logic [7:0] d);
        exp_q.push_back({7'h2C, r, d});
    endtask

    task automatic push_table();
        push(8'h00, 8'h01);
        push(8'h01, 8'h80);
        push(8'h02, 8'h1F);
        push(8'h03, 8'h1F);
        push(8'h10, 8'h05);
        push(8'h20, 8'h01);
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int n;
        n = 0;
        while (cfg_busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (cfg_busy !== lvl) begin
            checks++;
            errors++;
            $display("FAIL %s: cfg_busy=%b after %0d cycles, required %b", name, cfg_busy, n, lvl);
        end
    endtask

    task automatic run_seq(input string name);
        gap_pending = 1'b0;
        send_cfg    = 1'b1;
        wait_busy(1'b1, 10, name);
        repeat (2) @(negedge clk);
        send_cfg = 1'b0;
        wait_busy(1'b0, 3000, name);
        @(negedge clk);
    endtask

    task automatic clear_counts();
        req_cnt    = 0;
        watch_hits = 0;
    endtask

    // Master model: accepts immediately, answers 20 cycles later with a configurable NACK plan.
    initial begin
        int         wait_cnt;
        bit         pending;
        bit         nk;
        logic [7:0] r;
        wait_cnt     = 0;
        pending      = 1'b0;
        r            = 8'h00;
        bus.wr_ready = 1'b1;
        bus.wr_done  = 1'b0;
        bus.wr_nack  = 1'b0;
        forever begin
            @(negedge clk);
            bus.wr_done = 1'b0;
            bus.wr_nack = 1'b0;
            if (reset) begin
                pending = 1'b0;
            end else if (pending) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    pending = 1'b0;
                    if (respond_en) begin
                        nk = (r == nack_reg) && (nack_left > 0);
                        if (nk && nack_left < 255) nack_left--;
                        bus.wr_done = 1'b1;
                        bus.wr_nack = nk;
                        if (!nk) begin
                            gap_pending = 1'b1;
                            done_cyc    = cyc;
                        end
                    end
                end
            end else if (bus.wr_valid && bus.wr_ready) begin
                pending  = 1'b1;
                wait_cnt = 19;
                r        = bus.wr_reg_addr;
            end
        end
    end

    // Monitor: every accepted request is popped from the scoreboard and compared.
    initial begin
        logic        prev_v;
        logic [22:0] got;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && bus.wr_valid && bus.wr_ready) begin
                got     = {bus.wr_dev_addr, bus.wr_reg_addr, bus.wr_data};
                req_cnt++;
                acc_cyc = cyc + 1;
                if (bus.wr_reg_addr == watch_reg) watch_hits++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got 0x%0h required no request (cycle %0d)", got, cyc);
                end else begin
                    check("req", 32'(got), 32'(exp_q.pop_front()));
                end
            end
            if (bus.wr_valid && !prev_v && gap_pending) begin
`ifdef AMP_CFG_GAP_EN
                check("gap_idle_ge", 32'((cyc - done_cyc) >= int'(GAP)), 32'd1);
`endif
                gap_pending = 1'b0;
            end
            prev_v = bus.wr_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int n;
        int err_cyc;
        int vcnt;
        errors      = 0;
        checks      = 0;
        req_cnt     = 0;
        watch_hits  = 0;
        watch_reg   = 8'hEE;
        nack_reg    = 8'hEE;
        nack_left   = 0;
        respond_en  = 1'b1;
        acc_cyc     = 0;
        done_cyc    = 0;
        gap_pending = 1'b0;
        reset       = 1'b1;
        send_cfg    = 1'b1;

        // Reset values with send_cfg held high through release
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        check("rst_reg_addr", 32'(bus.wr_reg_addr), 32'd0);
        check("rst_data", 32'(bus.wr_data), 32'd0);
        check("rst_dev_addr", 32'(bus.wr_dev_addr), 32'h2C);
        check("rst_busy", 32'(cfg_busy), 32'd0);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_error", 32'(cfg_error), 32'd0);
        check("rst_index", 32'(cfg_index), 32'd0);
        repeat (10) @(negedge clk);
        check("held_no_busy", 32'(cfg_busy), 32'd0);
        check("held_no_req", 32'(req_cnt), 32'd0);
        send_cfg = 1'b0;
        repeat (3) @(negedge clk);

        // Nominal sequence and start latency
        clear_counts();
        push_table();
        send_cfg = 1'b1;
        lat = 0;
        while (bus.wr_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("start_latency", 32'(lat), 32'd3);
        wait_busy(1'b0, 3000, "nominal_end");
        send_cfg = 1'b0;
        @(negedge clk);
        check("nom_done", 32'(cfg_done), 32'd1);
        check("nom_busy", 32'(cfg_busy), 32'd0);
        check("nom_error", 32'(cfg_error), 32'd0);
        check("nom_index", 32'(cfg_index), 32'd5);
        check("nom_reqs", 32'(req_cnt), 32'd6);
        check("nom_sb_empty", 32'(exp_q.size()), 32'd0);

        // Restart clears cfg_done; second edge mid-sequence ignored
        repeat (3) @(negedge clk);
        clear_counts();
        push_table();
        gap_pending = 1'b0;
        send_cfg = 1'b1;
        wait_busy(1'b1, 10, "restart_busy");
        check("restart_done_clr", 32'(cfg_done), 32'd0);
        send_cfg = 1'b0;
        repeat (40) @(negedge clk);
        send_cfg = 1'b1;
        repeat (5) @(negedge clk);
        send_cfg = 1'b0;
        wait_busy(1'b0, 3000, "restart_end");
        @(negedge clk);
        check("restart_done", 32'(cfg_done), 32'd1);
        check("restart_reqs", 32'(req_cnt), 32'd6);
        repeat (20) @(negedge clk);
        check("restart_no_requeue", 32'(cfg_busy), 32'd0);
        check("restart_sb_empty", 32'(exp_q.size()), 32'd0);

        // Retry recovery: reg 02 NACKs twice then ACKs
        clear_counts();
        watch_reg = 8'h02;
        nack_reg  = 8'h02;
        nack_left = 2;
        push(8'h00, 8'h01);
        push(8'h01, 8'h80);
        push(8'h02, 8'h1F);
        push(8'h02, 8'h1F);
        push(8'h02, 8'h1F);
        push(8'h03, 8'h1F);
        push(8'h10, 8'h05);
        push(8'h20, 8'h01);
        run_seq("retry_ok");
        check("retry_done", 32'(cfg_done), 32'd1);
        check("retry_error", 32'(cfg_error), 32'd0);
        check("retry_reg02_hits", 32'(watch_hits), 32'd3);
        check("retry_reqs", 32'(req_cnt), 32'd8);
        check("retry_sb_empty", 32'(exp_q.size()), 32'd0);

        // Retry exhaustion: reg 01 always NACKs
        clear_counts();
        watch_reg = 8'h01;
        nack_reg  = 8'h01;
        nack_left = 255;
        push(8'h00, 8'h01);
        for (int i = 0; i < 4; i++) push(8'h01, 8'h80);
        run_seq("retry_exhaust");
        check("exh_error", 32'(cfg_error), 32'd1);
        check("exh_done", 32'(cfg_done), 32'd0);
        check("exh_index", 32'(cfg_index), 32'd1);
        check("exh_reg01_hits", 32'(watch_hits), 32'd4);
        repeat (30) @(negedge clk);
        check("exh_reqs", 32'(req_cnt), 32'd5);
        check("exh_sb_empty", 32'(exp_q.size()), 32'd0);
        nack_reg  = 8'hEE;
        nack_left = 0;
        watch_reg = 8'hEE;

        // Timeout: no wr_done for entry 0
        clear_counts();
        respond_en = 1'b0;
        push(8'h00, 8'h01);
        gap_pending = 1'b0;
        send_cfg = 1'b1;
        wait_busy(1'b1, 10, "tmo_busy");
        n = 0;
        while (cfg_error !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        err_cyc = cyc;
        check("tmo_error", 32'(cfg_error), 32'd1);
        check("tmo_cycles", 32'(err_cyc - acc_cyc), 32'(TMO));
        check("tmo_index", 32'(cfg_index), 32'd0);
        send_cfg = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.wr_valid) vcnt++;
        end
        check("tmo_valid_low", 32'(vcnt), 32'd0);
        check("tmo_busy", 32'(cfg_busy), 32'd0);
        check("tmo_reqs", 32'(req_cnt), 32'd1);
        respond_en = 1'b1;
        repeat (5) @(negedge clk);

        // Reset during WAIT of entry 3
        clear_counts();
        push(8'h00, 8'h01);
        push(8'h01, 8'h80);
        push(8'h02, 8'h1F);
        push(8'h03, 8'h1F);
        gap_pending = 1'b0;
        send_cfg = 1'b1;
        n = 0;
        while (req_cnt < 4 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached_entry3", 32'(req_cnt), 32'd4);
        repeat (5) @(negedge clk);
        send_cfg = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("mid_rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        check("mid_rst_reg_addr", 32'(bus.wr_reg_addr), 32'd0);
        check("mid_rst_data", 32'(bus.wr_data), 32'd0);
        check("mid_rst_busy", 32'(cfg_busy), 32'd0);
        check("mid_rst_done", 32'(cfg_done), 32'd0);
        check("mid_rst_error", 32'(cfg_error), 32'd0);
        check("mid_rst_index", 32'(cfg_index), 32'd0);
        reset = 1'b0;
        gap_pending = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.wr_valid) vcnt++;
        end
        check("mid_no_valid", 32'(vcnt), 32'd0);
        check("mid_sb_empty", 32'(exp_q.size()), 32'd0);

        // Fresh sequence after reset
        clear_counts();
        push_table();
        run_seq("post_reset");
        check("post_done", 32'(cfg_done), 32'd1);
        check("post_error", 32'(cfg_error), 32'd0);
        check("post_reqs", 32'(req_cnt), 32'd6);
        check("post_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
